nes_pad_scanner: RTL and testbench

Sequences the two NES controller ports behind CPU addresses $4016/$4017. Runs a free-running scan engine that drives the physical pad latch/clock lines and captures both 8-bit button snapshots. It also implements the CPU-visible strobe register and the per-port 8-bit read shift registers. It sits on the CPU bus decode in place of the idle controller stub and is the only agent that drives the pad wires.

---
 rtl/nes_pad_scanner.sv | 268 ++++++++++++++++++++++++++
 tb/tb_nes_pad_scanner.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nes_pad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : nes_pad_scanner
// Description : NES controller port engine for $4016/$4017. A free-running
//               scan FSM drives the pad latch/clock lines and captures both
//               button bytes; the CPU side provides the strobe register and
//               the per-port serial read shift registers.
//               Optional: define NES_PAD_DEBOUNCE_EN to commit a port's
//               snapshot only after two consecutive matching scans.
// Revision    : 1.0 - initial release
// ============================================================================
module nes_pad_scanner #(
    parameter int SCAN_DIV = 6,
    parameter int SCAN_GAP = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       rw,
    input  logic       addr,
    input  logic [7:0] cpu_wdata,
    output logic [7:0] cpu_rdata,
    output logic       cpu_rdata_oe,
    output logic       pad_latch,
    output logic       pad_clk,
    input  logic [1:0] pad_data,
    output logic [7:0] btn_p1,
    output logic [7:0] btn_p2,
    output logic       scan_done
);

    localparam int c_CNT_MAX = (SCAN_GAP > 2 * SCAN_DIV) ? SCAN_GAP : 2 * SCAN_DIV;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_GAP_LOAD   = c_CNT_W'(SCAN_GAP - 1);
    localparam logic [c_CNT_W-1:0] c_LATCH_LOAD = c_CNT_W'(2 * SCAN_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LOAD  = c_CNT_W'(SCAN_DIV - 1);

    typedef enum logic [2:0] {
        S_GAP    = 3'd0,
        S_LATCH  = 3'd1,
        S_CLK_HI = 3'd2,
        S_CLK_LO = 3'd3,
        S_COMMIT = 3'd4
    } scan_state_t;

    scan_state_t        r_state;
    scan_state_t        w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [2:0]         r_bit;
    logic [2:0]         w_bit_nxt;
    logic               w_sample;
    logic               w_cnt_zero;

    logic [7:0] r_cap_p1;
    logic [7:0] r_cap_p2;
    logic [7:0] r_btn_p1;
    logic [7:0] r_btn_p2;
    logic [7:0] w_commit_p1;
    logic [7:0] w_commit_p2;
    logic       r_pad_latch;
    logic       r_pad_clk;
    logic       r_scan_done;

    // ------------------------------------------------------------------
    // Scan FSM
    // ------------------------------------------------------------------
    assign w_cnt_zero = (r_cnt == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_sample    = 1'b0;
        case (r_state)
            S_GAP: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_LATCH;
                    w_cnt_nxt   = c_LATCH_LOAD;
                    w_bit_nxt   = 3'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_LATCH: begin
                if (w_cnt_zero) begin
                    w_sample    = 1'b1;
                    w_state_nxt = S_CLK_HI;
                    w_cnt_nxt   = c_HALF_LOAD;
                    w_bit_nxt   = 3'd1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_CLK_HI: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_CLK_LO;
                    w_cnt_nxt   = c_HALF_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_CLK_LO: begin
                if (w_cnt_zero) begin
                    w_sample = 1'b1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_COMMIT;
                    end else begin
                        w_state_nxt = S_CLK_HI;
                        w_cnt_nxt   = c_HALF_LOAD;
                        w_bit_nxt   = r_bit + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_COMMIT: begin
                w_state_nxt = S_GAP;
                w_cnt_nxt   = c_GAP_LOAD;
            end
            default: begin
                w_state_nxt = S_GAP;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Pad lines and scan_done are registered from the next state so they
    // line up exactly with the state they describe and never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_GAP;
            r_cnt       <= '0;
            r_bit       <= 3'd0;
            r_pad_latch <= 1'b0;
            r_pad_clk   <= 1'b0;
            r_scan_done <= 1'b0;
            r_cap_p1    <= 8'h00;
            r_cap_p2    <= 8'h00;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit       <= w_bit_nxt;
            r_pad_latch <= (w_state_nxt == S_LATCH);
            r_pad_clk   <= (w_state_nxt == S_CLK_HI);
            r_scan_done <= (w_state_nxt == S_COMMIT);
            if (w_sample) begin
                r_cap_p1[r_bit] <= ~pad_data[0];
                r_cap_p2[r_bit] <= ~pad_data[1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Snapshot commit
    // ------------------------------------------------------------------
`ifdef NES_PAD_DEBOUNCE_EN
    logic [7:0] r_prev_p1;
    logic [7:0] r_prev_p2;

    assign w_commit_p1 = (r_cap_p1 == r_prev_p1) ? r_cap_p1 : r_btn_p1;
    assign w_commit_p2 = (r_cap_p2 == r_prev_p2) ? r_cap_p2 : r_btn_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_p1 <= 8'h00;
            r_prev_p2 <= 8'h00;
        end else if (r_state == S_COMMIT) begin
            r_prev_p1 <= r_cap_p1;
            r_prev_p2 <= r_cap_p2;
        end
    end
`else
    assign w_commit_p1 = r_cap_p1;
    assign w_commit_p2 = r_cap_p2;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_p1 <= 8'h00;
            r_btn_p2 <= 8'h00;
        end else if (r_state == S_COMMIT) begin
            r_btn_p1 <= w_commit_p1;
            r_btn_p2 <= w_commit_p2;
        end
    end

    // ------------------------------------------------------------------
    // CPU strobe register and serial read shift registers
    // ------------------------------------------------------------------
    logic       r_cs_prev;
    logic       r_acc_rd;
    logic       r_acc_port;
    logic       r_strobe;
    logic [7:0] r_shift_p1;
    logic [7:0] r_shift_p2;
    logic       w_acc_start;
    logic       w_acc_end;
    logic [7:0] w_reload_p1;
    logic [7:0] w_reload_p2;
    logic       w_rd_bit;
    logic       w_unused_wdata;

    assign w_acc_start = r_cs_prev & ~cs;
    assign w_acc_end   = ~r_cs_prev & cs;

    // A reload in the commit cycle must see the snapshot being written.
    assign w_reload_p1 = (r_state == S_COMMIT) ? w_commit_p1 : r_btn_p1;
    assign w_reload_p2 = (r_state == S_COMMIT) ? w_commit_p2 : r_btn_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cs_prev  <= 1'b1;
            r_acc_rd   <= 1'b0;
            r_acc_port <= 1'b0;
            r_strobe   <= 1'b0;
        end else begin
            r_cs_prev <= cs;
            if (w_acc_start) begin
                r_acc_rd   <= rw;
                r_acc_port <= addr;
                if (!rw && !addr) begin
                    r_strobe <= cpu_wdata[0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift_p1 <= 8'h00;
            r_shift_p2 <= 8'h00;
        end else if (r_strobe) begin
            r_shift_p1 <= w_reload_p1;
            r_shift_p2 <= w_reload_p2;
        end else if (w_acc_end && r_acc_rd) begin
            if (r_acc_port) begin
                r_shift_p2 <= {1'b1, r_shift_p2[7:1]};
            end else begin
                r_shift_p1 <= {1'b1, r_shift_p1[7:1]};
            end
        end
    end

    // The shift register lags the strobe by a cycle, so strobed reads
    // take button A straight from the snapshot.
    always_comb begin
        w_rd_bit = 1'b0;
        if (addr) begin
            w_rd_bit = r_strobe ? r_btn_p2[0] : r_shift_p2[0];
        end else begin
            w_rd_bit = r_strobe ? r_btn_p1[0] : r_shift_p1[0];
        end
    end

    assign w_unused_wdata = &{1'b0, cpu_wdata[7:1]};

    assign cpu_rdata    = {7'b0, w_rd_bit};
    assign cpu_rdata_oe = ~rst & ~cs & rw;
    assign pad_latch    = r_pad_latch;
    assign pad_clk      = r_pad_clk;
    assign btn_p1       = r_btn_p1;
    assign btn_p2       = r_btn_p2;
    assign scan_done    = r_scan_done;

endmodule
`default_nettype wire

// File: tb/tb_nes_pad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_nes_pad_scanner
// Description : Directed self-checking bench for nes_pad_scanner with a
//               behavioural model of two NES pads on the latch/clock lines.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nes_pad_scanner;

`ifdef NES_PAD_DEBOUNCE_EN
    localparam int c_SCANS = 3;
`else
    localparam int c_SCANS = 2;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       cs;
    logic       rw;
    logic       addr;
    logic [7:0] cpu_wdata;
    logic [7:0] cpu_rdata;
    logic       cpu_rdata_oe;
    logic       pad_latch;
    logic       pad_clk;
    logic [1:0] pad_data;
    logic [7:0] btn_p1;
    logic [7:0] btn_p2;
    logic       scan_done;

    int checks = 0;
    int errors = 0;

    // Pad model: parallel load while latched, shift on pad_clk rising edge.
    logic [7:0] pad_btn1 = 8'h00;
    logic [7:0] pad_btn2 = 8'h00;
    logic [7:0] sr1 = 8'h00;
    logic [7:0] sr2 = 8'h00;
    logic       pclk_q = 1'b0;

    always #5 clk = ~clk;

    nes_pad_scanner dut (
        .clk          (clk),
        .rst          (rst),
        .cs           (cs),
        .rw           (rw),
        .addr         (addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .cpu_rdata_oe (cpu_rdata_oe),
        .pad_latch    (pad_latch),
        .pad_clk      (pad_clk),
        .pad_data     (pad_data),
        .btn_p1       (btn_p1),
        .btn_p2       (btn_p2),
        .scan_done    (scan_done)
    );

    always @(posedge clk) begin
        pclk_q <= pad_clk;
        if (pad_latch) begin
            sr1 <= pad_btn1;
            sr2 <= pad_btn2;
        end else if (pad_clk && !pclk_q) begin
            sr1 <= {1'b0, sr1[7:1]};
            sr2 <= {1'b0, sr2[7:1]};
        end
    end

    assign pad_data = {~sr2[0], ~sr1[0]};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_scans(input int n);
        for (int k = 0; k < n; k++) begin
            int cyc;
            cyc = 0;
            while (!scan_done && cyc < 3000) begin
                tick();
                cyc++;
            end
            check("scan_timeout", 32'(cyc < 3000), 32'd1);
            tick();
        end
    endtask

    task automatic cpu_write(input logic a, input logic [7:0] d);
        cs = 1'b0; rw = 1'b0; addr = a; cpu_wdata = d;
        tick();
        cs = 1'b1; rw = 1'b1; cpu_wdata = 8'h00;
        tick();
    endtask

    task automatic rd_chk(input string tag, input logic a, input logic exp);
        cs = 1'b0; rw = 1'b1; addr = a;
        #1;
        check({tag, "_oe"}, 32'(cpu_rdata_oe), 32'd1);
        check(tag, 32'(cpu_rdata), 32'(exp));
        tick();
        cs = 1'b1;
        tick();
    endtask

    initial begin
        int  c;
        int  lat;
        int  clks;
        int  n;
        logic prev;
        logic [9:0] seq1;

        rst = 1'b1; cs = 1'b1; rw = 1'b1; addr = 1'b0; cpu_wdata = 8'h00;
        repeat (3) tick();
        check("rst_latch", 32'(pad_latch), 32'd0);
        check("rst_clk", 32'(pad_clk), 32'd0);
        check("rst_btn1", 32'(btn_p1), 32'h00);
        check("rst_btn2", 32'(btn_p2), 32'h00);
        check("rst_done", 32'(scan_done), 32'd0);
        check("rst_oe", 32'(cpu_rdata_oe), 32'd0);

        // First scan after reset: latch one cycle after release.
        rst = 1'b0;
        #1;
        check("gap_cycle", 32'(pad_latch), 32'd0);
        tick();
        check("latch_rise", 32'(pad_latch), 32'd1);
        c = 0; lat = 0; clks = 0; prev = 1'b0;
        while (!scan_done && c < 300) begin
            if (pad_latch) lat++;
            if (pad_clk && !prev) clks++;
            prev = pad_clk;
            tick();
            c++;
        end
        check("scan_len", 32'(c), 32'd96);
        check("latch_len", 32'(lat), 32'd12);
        check("clk_pulses", 32'(clks), 32'd7);
        tick();
        check("done_pulse", 32'(scan_done), 32'd0);
        check("idle_btn1", 32'(btn_p1), 32'h00);
        check("idle_btn2", 32'(btn_p2), 32'h00);

        // Port 1: A, Start, Right.
        pad_btn1 = 8'h89;
        wait_scans(c_SCANS);
        check("p1_btn1", 32'(btn_p1), 32'h89);
        check("p1_btn2", 32'(btn_p2), 32'h00);
        pad_btn2 = 8'h06;
        wait_scans(c_SCANS);
        check("p2_btn2", 32'(btn_p2), 32'h06);
        check("p2_btn1", 32'(btn_p1), 32'h89);

        // Strobe pulse then serial reads, with port 2 interleaved.
        cpu_write(1'b0, 8'h01);
        cpu_write(1'b0, 8'h00);
        seq1 = 10'b11_1000_1001;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) rd_chk("rd4017_a", 1'b1, 1'b0);
            rd_chk($sformatf("rd4016_%0d", i), 1'b0, seq1[i]);
        end
        rd_chk("rd4017_b", 1'b1, 1'b1);
        rd_chk("rd4017_c", 1'b1, 1'b1);

        // Strobe held: reads return A without shifting.
        cpu_write(1'b0, 8'h01);
        for (int i = 0; i < 3; i++) rd_chk($sformatf("strb_%0d", i), 1'b0, 1'b1);
        pad_btn1 = 8'h8A;
        wait_scans(c_SCANS);
        check("strb_btn1", 32'(btn_p1), 32'h8A);
        rd_chk("strb_new", 1'b0, 1'b0);
        cpu_write(1'b0, 8'h00);

        // One long read (cs low 5 cycles) shifts exactly once.
        cs = 1'b0; rw = 1'b1; addr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("long_oe", 32'(cpu_rdata_oe), 32'd1);
            check("long_bit", 32'(cpu_rdata), 32'h00);
            @(posedge clk);
            #1;
        end
        cs = 1'b1;
        #1;
        check("long_oe_off", 32'(cpu_rdata_oe), 32'd0);
        tick();
        rd_chk("long_next1", 1'b0, 1'b1);
        rd_chk("long_next2", 1'b0, 1'b0);
        cpu_write(1'b1, 8'h01);
        rd_chk("w4017_ignored", 1'b0, 1'b1);

        // Reset during CLK_LO of bit 4.
        c = 0;
        while (!pad_latch && c < 3000) begin
            tick();
            c++;
        end
        check("latch_found", 32'(pad_latch), 32'd1);
        n = 0; prev = 1'b0; c = 0;
        while (!(n == 4 && !pad_clk) && c < 300) begin
            tick();
            if (pad_clk && !prev) n++;
            prev = pad_clk;
            c++;
        end
        check("bit4_found", 32'(n), 32'd4);
        tick();
        rst = 1'b1;
        tick();
        check("mid_rst_clk", 32'(pad_clk), 32'd0);
        check("mid_rst_latch", 32'(pad_latch), 32'd0);
        check("mid_rst_btn1", 32'(btn_p1), 32'h00);
        check("mid_rst_btn2", 32'(btn_p2), 32'h00);
        pad_btn1 = 8'h10;
        pad_btn2 = 8'h00;
        tick();
        rst = 1'b0;
        rd_chk("post_rst_rd", 1'b0, 1'b0);

`ifdef NES_PAD_DEBOUNCE_EN
        // Alternating button never survives two matching scans.
        for (int k = 0; k < 4; k++) begin
            wait_scans(1);
            check($sformatf("deb_%0d", k), 32'(btn_p1), 32'h00);
            pad_btn1 = (k % 2 == 0) ? 8'h00 : 8'h10;
        end
`else
        wait_scans(1);
        check("alt_on", 32'(btn_p1), 32'h10);
        pad_btn1 = 8'h00;
        wait_scans(1);
        check("alt_off", 32'(btn_p1), 32'h00);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
